// File: rtl/id_ex_skid_stage_pkg.sv
// Shared pipeline-register definitions: default payload widths and the
// EMPTY/ONE/TWO occupancy encoding used by all skid-buffered stage registers
// (IF/ID, ID/EX, EX/MEM, MEM/WB).
package id_ex_skid_stage_pkg;

  // Default payload widths.
  localparam int unsigned CTRL_W_DEF      = 24;
  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned DEST_W_DEF      = 5;

  // instr, pa, pb, pc, rs_addr all share DATA_W.
  localparam int unsigned NUM_DATA_FIELDS = 5;

  // Occupancy state encoding; the value doubles as the entry count.
  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_EMPTY = 2'd0;
  localparam logic [STATE_W-1:0] ST_ONE   = 2'd1;
  localparam logic [STATE_W-1:0] ST_TWO   = 2'd2;

  // Width of the flattened stage payload.
  function automatic int unsigned payload_width(input int unsigned ctrl_w,
                                                input int unsigned data_w,
                                                input int unsigned dest_w);
    return ctrl_w + NUM_DATA_FIELDS * data_w + dest_w;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry skid buffer: a main register that drives the output and
// one skid register that absorbs an entry while the consumer stalls.
// in_ready depends only on state and reset, never on out_ready.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   flush           discard held and incoming entries
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload (main reg)
//   occupancy       number of held entries (0..2)
module pipe_skid_buf
  import id_ex_skid_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nx;
  logic [WIDTH-1:0]   main_q;
  logic [WIDTH-1:0]   main_nx;
  logic [WIDTH-1:0]   skid_q;
  logic [WIDTH-1:0]   skid_nx;
  logic               xfer_in;
  logic               xfer_out;

  // State and payload registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_nx;
      main_q <= main_nx;
      skid_q <= skid_nx;
    end
  end

  // Handshake decode and next-state / next-payload selection.
  always_comb begin
    state_nx  = state;
    main_nx   = main_q;
    skid_nx   = skid_q;
    in_ready  = (state != ST_TWO) && !reset;
    out_valid = (state != ST_EMPTY);
    xfer_in   = in_valid && in_ready && !flush;
    xfer_out  = out_valid && out_ready;

    case (state)
      ST_EMPTY: begin
        if (xfer_in) begin
          state_nx = ST_ONE;
          main_nx  = in_data;
        end
      end
      ST_ONE: begin
        case ({xfer_in, xfer_out})
          2'b10: begin
            state_nx = ST_TWO;
            skid_nx  = in_data;
          end
          2'b01: state_nx = ST_EMPTY;
          2'b11: main_nx  = in_data;
          default: state_nx = ST_ONE;
        endcase
      end
      ST_TWO: begin
        if (xfer_out) begin
          state_nx = ST_ONE;
          main_nx  = skid_q;
        end
      end
      default: state_nx = ST_EMPTY;
    endcase

    // Squash wins over every transition; a same-cycle consume already happened.
    if (flush) begin
      state_nx = ST_EMPTY;
    end
  end

  assign out_data  = main_q;
  assign occupancy = state;

endmodule

// File: rtl/id_ex_skid_stage.sv
// ID/EX pipeline register with skid buffering. Thin wrapper that flattens
// the ID payload into one vector for pipe_skid_buf and unpacks it for EX.
// out_ctrl is forced to zero for bubbles so no write/memory enable leaks.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   flush             branch/jump squash of held and incoming entries
//   in_valid/in_ready upstream (ID) handshake
//   in_*              ctrl, instr, pa, pb, pc, rs_addr, dest from ID
//   out_valid/out_ready downstream (EX) handshake
//   out_*             payload to EX
//   occupancy         held entries (0..2)
module id_ex_skid_stage
  import id_ex_skid_stage_pkg::*;
#(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEST_W = DEST_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pa,
  input  logic [DATA_W-1:0] in_pb,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_rs_addr,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_pa,
  output logic [DATA_W-1:0] out_pb,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_rs_addr,
  output logic [DEST_W-1:0] out_dest,
  output logic [1:0]        occupancy
);

  localparam int unsigned PAYLOAD_W = payload_width(CTRL_W, DATA_W, DEST_W);

  logic [PAYLOAD_W-1:0] in_data;
  logic [PAYLOAD_W-1:0] out_data;
  logic [CTRL_W-1:0]    main_ctrl;

  assign in_data = {in_ctrl, in_instr, in_pa, in_pb, in_pc, in_rs_addr, in_dest};

  pipe_skid_buf #(
    .WIDTH (PAYLOAD_W)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  assign {main_ctrl, out_instr, out_pa, out_pb, out_pc, out_rs_addr, out_dest} = out_data;

  // Bubbles carry no enables; data fields keep the last main value.
  assign out_ctrl = out_valid ? main_ctrl : '0;

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Self-checking bench for id_ex_skid_stage: directed table, streaming run,
// and randomized traffic against a queue-based reference model.
module tb_id_ex_skid_stage;

  localparam int unsigned CW  = 24;
  localparam int unsigned DW  = 32;
  localparam int unsigned DSW = 5;

  typedef struct packed {
    logic [CW-1:0]  ctrl;
    logic [DW-1:0]  instr;
    logic [DW-1:0]  pa;
    logic [DW-1:0]  pb;
    logic [DW-1:0]  pc;
    logic [DW-1:0]  rs_addr;
    logic [DSW-1:0] dest;
  } entry_t;

  // ins = {reset, flush, in_valid, out_ready}; exp = {out_valid, in_ready, all_zero}
  typedef struct packed {
    logic [3:0]  ins;
    logic [31:0] pc;
    logic [1:0]  occ;
    logic [2:0]  exp;
    logic [31:0] epc;
  } vec_t;

  logic clk;
  logic reset, flush, in_valid, out_ready;
  logic in_ready, out_valid;
  logic [1:0] occupancy;
  entry_t in_e;
  entry_t out_e;
  logic [CW-1:0]  out_ctrl;
  logic [DW-1:0]  out_instr, out_pa, out_pb, out_pc, out_rs_addr;
  logic [DSW-1:0] out_dest;

  int passed = 0;
  int total  = 0;

  id_ex_skid_stage dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ctrl     (in_e.ctrl),
    .in_instr    (in_e.instr),
    .in_pa       (in_e.pa),
    .in_pb       (in_e.pb),
    .in_pc       (in_e.pc),
    .in_rs_addr  (in_e.rs_addr),
    .in_dest     (in_e.dest),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_ctrl    (out_ctrl),
    .out_instr   (out_instr),
    .out_pa      (out_pa),
    .out_pb      (out_pb),
    .out_pc      (out_pc),
    .out_rs_addr (out_rs_addr),
    .out_dest    (out_dest),
    .occupancy   (occupancy)
  );

  assign out_e = {out_ctrl, out_instr, out_pa, out_pb, out_pc, out_rs_addr, out_dest};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Distinct, nonzero-ctrl payload derived from a pc value.
  function automatic entry_t mk_entry(input logic [31:0] pc);
    entry_t e;
    e.ctrl    = {8'hC3, pc[15:0]};
    e.instr   = pc ^ 32'hDEADBEEF;
    e.pa      = pc + 32'd1;
    e.pb      = ~pc;
    e.pc      = pc;
    e.rs_addr = pc << 2;
    e.dest    = pc[6:2];
    return e;
  endfunction

  function automatic vec_t mk_vec(input logic [3:0] ins, input logic [31:0] pc,
                                  input logic [1:0] occ, input logic [2:0] exp,
                                  input logic [31:0] epc);
    vec_t v;
    v.ins = ins; v.pc = pc; v.occ = occ; v.exp = exp; v.epc = epc;
    return v;
  endfunction

  vec_t   vt[20];
  entry_t q[$];
  entry_t exp_e;
  int     seq;
  logic   take_in, take_out;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_e  = '0;

    // Directed table: each row's expectations hold just after its clock edge.
    vt[0]  = mk_vec(4'b1000, 32'h00, 2'd0, 3'b001, 32'h00);
    vt[1]  = mk_vec(4'b0011, 32'h04, 2'd1, 3'b110, 32'h04);
    vt[2]  = mk_vec(4'b0011, 32'h08, 2'd1, 3'b110, 32'h08);
    vt[3]  = mk_vec(4'b0010, 32'h0C, 2'd2, 3'b100, 32'h08);
    vt[4]  = mk_vec(4'b0010, 32'h10, 2'd2, 3'b100, 32'h08);
    vt[5]  = mk_vec(4'b0001, 32'h00, 2'd1, 3'b110, 32'h0C);
    vt[6]  = mk_vec(4'b0001, 32'h00, 2'd0, 3'b010, 32'h00);
    vt[7]  = mk_vec(4'b0010, 32'h20, 2'd1, 3'b110, 32'h20);
    vt[8]  = mk_vec(4'b0010, 32'h24, 2'd2, 3'b100, 32'h20);
    vt[9]  = mk_vec(4'b0110, 32'h40, 2'd0, 3'b010, 32'h00);
    vt[10] = mk_vec(4'b0011, 32'h44, 2'd1, 3'b110, 32'h44);
    vt[11] = mk_vec(4'b0010, 32'h48, 2'd2, 3'b100, 32'h44);
    vt[12] = mk_vec(4'b1010, 32'h4C, 2'd0, 3'b001, 32'h00);
    vt[13] = mk_vec(4'b0000, 32'h00, 2'd0, 3'b011, 32'h00);
    vt[14] = mk_vec(4'b0011, 32'h50, 2'd1, 3'b110, 32'h50);
    vt[15] = mk_vec(4'b0001, 32'h00, 2'd0, 3'b010, 32'h00);
    vt[16] = mk_vec(4'b0010, 32'h60, 2'd1, 3'b110, 32'h60);
    vt[17] = mk_vec(4'b0010, 32'h64, 2'd2, 3'b100, 32'h60);
    vt[18] = mk_vec(4'b0111, 32'h68, 2'd0, 3'b010, 32'h00);
    vt[19] = mk_vec(4'b0001, 32'h00, 2'd0, 3'b010, 32'h00);

    for (int i = 0; i < 20; i++) begin
      {reset, flush, in_valid, out_ready} = vt[i].ins;
      in_e = mk_entry(vt[i].pc);
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_out_valid", i), 192'(out_valid), 192'(vt[i].exp[2]));
      check($sformatf("tbl%0d_in_ready", i), 192'(in_ready), 192'(vt[i].exp[1]));
      check($sformatf("tbl%0d_occupancy", i), 192'(occupancy), 192'(vt[i].occ));
      if (vt[i].exp[0])
        check($sformatf("tbl%0d_all_zero", i), 192'(out_e), 192'(0));
      else if (vt[i].exp[2])
        check($sformatf("tbl%0d_payload", i), 192'(out_e), 192'(mk_entry(vt[i].epc)));
      else
        check($sformatf("tbl%0d_bubble_ctrl", i), 192'(out_ctrl), 192'(0));
    end

    // Streaming: one in, one out per cycle, in order, never back-pressured.
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_e = mk_entry(32'(i * 4));
      #1;
      check($sformatf("stream%0d_in_ready", i), 192'(in_ready), 192'(1));
      @(posedge clk);
      #1;
      check($sformatf("stream%0d_payload", i), 192'(out_e), 192'(mk_entry(32'(i * 4))));
      check($sformatf("stream%0d_occupancy", i), 192'(occupancy), 192'(1));
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("stream_drain_valid", 192'(out_valid), 192'(0));

    // Randomized traffic against a queue model of held entries.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    seq = 32'h1000;
    for (int c = 0; c < 1000; c++) begin
      reset     = ($urandom_range(0, 199) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_e       = mk_entry(32'(seq));
      in_e.instr = $urandom();
      in_e.ctrl  = CW'($urandom()) | CW'(1);
      seq += 4;

      @(negedge clk);
      check("rnd_in_ready", 192'(in_ready), 192'(!reset && (q.size() < 2)));
      check("rnd_out_valid", 192'(out_valid), 192'(q.size() > 0));
      check("rnd_occupancy", 192'(occupancy), 192'(q.size()));
      if (q.size() > 0) begin
        exp_e = q[0];
        check("rnd_payload", 192'(out_e), 192'(exp_e));
      end else begin
        check("rnd_bubble_ctrl", 192'(out_ctrl), 192'(0));
      end

      @(posedge clk);
      if (reset) begin
        q.delete();
      end else begin
        take_in  = in_valid && (q.size() < 2) && !flush;
        take_out = (q.size() > 0) && out_ready;
        if (take_out) void'(q.pop_front());
        if (take_in) q.push_back(in_e);
        if (flush) q.delete();
      end
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
